gshare_btb_predictor: RTL and testbench
=======================================

GSHARE_BTB_PREDICTOR -- requirements
Module: gshare_btb_predictor

Interface
REQ-001 Parameter XLEN, default 32, address/target width.
REQ-002 Parameter SCALE, default 10, table depth 2^SCALE entries (counter table and BTB).
REQ-003 Parameter TAG_W, default 8, BTB tag width; tag = pc[2+SCALE +: TAG_W].
REQ-004 Parameter GHR_LEN, default 8, global history length, 1..SCALE.
REQ-005 Parameter MODE, default 1; 0 = bimodal index, 1 = gshare index.
REQ-006 clk  input  1  single clock; all state changes on rising edge.
REQ-007 rst  input  1  asynchronous, active-high reset.
REQ-008 bp_oe  input  1  lookup enable; low = hold previous lookup outputs (stall).
REQ-009 bp_pc  input  XLEN  lookup PC.
REQ-010 bp_taken  output  1  predicted taken.
REQ-011 bp_target  output  XLEN  predicted target.
REQ-012 bp_meta  output  SCALE+2  {index, counter} checkpoint, carried down the pipeline.
REQ-013 fb_we  input  1  feedback valid (resolved control transfer).
REQ-014 fb_pc  input  XLEN  PC of resolved instruction.
REQ-015 fb_taken  input  1  resolved direction.
REQ-016 fb_target  input  XLEN  resolved target.
REQ-017 fb_meta  input  SCALE+2  bp_meta returned for that instruction.
REQ-018 ready  output  1  high when tables are initialised.

Function
REQ-019 Counter index SHALL be pc[2+:SCALE] when MODE=0, and pc[2+:SCALE] XOR zero-extended GHR when MODE=1; BTB index SHALL always be pc[2+:SCALE].
REQ-020 Lookup latency SHALL be 1 cycle: bp_oe&&ready at edge n -> bp_taken/bp_target/bp_meta valid after edge n and held until the next enabled lookup.
REQ-021 bp_taken SHALL be counter[1] AND BTB valid AND tag match; bp_target SHALL be the stored target with bit 0 cleared, or 0 on miss.
REQ-022 bp_meta SHALL be {counter index used, counter value read}.
REQ-023 On fb_we&&ready, counter at fb_meta index SHALL be written with fb_meta counter saturating: taken -> min(c+1,3), not taken -> max(c-1,0).
REQ-024 On fb_we&&ready&&fb_taken, BTB at fb_pc index SHALL be written {valid=1, tag(fb_pc), fb_target&~1}; not-taken feedback SHALL NOT touch the BTB.
REQ-025 GHR SHALL update only on fb_we&&ready: GHR <= {GHR[GHR_LEN-2:0], fb_taken} (non-speculative).
REQ-026 Same-edge lookup and feedback to the same index: lookup SHALL return pre-write data.
REQ-027 FSM states INIT, RUN: INIT walks a counter 0..2^SCALE-1, one entry per cycle, writing counter=2'b01, valid=0; RUN entered the cycle after the last entry is written.
REQ-028 ready SHALL be 1 only in RUN; in INIT bp_oe and fb_we SHALL be ignored and bp_taken SHALL be 0.
REQ-029 Index arithmetic SHALL be SCALE bits wide, wrapping modulo 2^SCALE.

Reset
REQ-030 rst high SHALL immediately force: state INIT, walk counter 0, GHR 0, ready 0, bp_taken 0, bp_target 0, bp_meta 0.
REQ-031 rst asserted mid-walk or mid-RUN SHALL restart the full INIT walk after deassertion.

Verification (SCALE=4, TAG_W=8, GHR_LEN=4)
REQ-032 rst 3 cycles then release -> ready low exactly 16 cycles, then 1; lookup pc 0x40 -> bp_taken 0, bp_meta {0x0,2'b01}.
REQ-033 MODE=0: feedback pc 0x40 taken target 0x101 meta {0,01}, then meta {0,10} -> lookup 0x40 gives taken 1, target 0x100, meta {0,11}.
REQ-034 Saturation: feedback taken with meta counter 11 -> counter stays 11; not taken with 00 -> stays 00.
REQ-035 Tag miss: after REQ-033, lookup 0x440 (index 0, tag 0x11) -> bp_taken 0, bp_target 0.
REQ-036 MODE=1: feedback T,T,N,T -> GHR 4'b1101; lookup 0x40 -> bp_meta index 0xD; same-edge feedback to index 0xD -> lookup shows old counter.
REQ-037 rst pulse at walk step 7 -> ready stays low 16 full cycles after release; fb_we during INIT leaves tables unchanged.

Source files
------------

// File: rtl/gshare_btb_predictor.sv
// Gshare/bimodal direction predictor with a direct-mapped BTB.
// Tables are cleared by a one-entry-per-cycle walk after reset; ready rises when the walk completes.
module gshare_btb_predictor #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned SCALE   = 10,
  parameter int unsigned TAG_W   = 8,
  parameter int unsigned GHR_LEN = 8,
  parameter int unsigned MODE    = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               bp_oe,
  input  logic [XLEN-1:0]    bp_pc,
  output logic               bp_taken,
  output logic [XLEN-1:0]    bp_target,
  output logic [SCALE+1:0]   bp_meta,
  input  logic               fb_we,
  input  logic [XLEN-1:0]    fb_pc,
  input  logic               fb_taken,
  input  logic [XLEN-1:0]    fb_target,
  input  logic [SCALE+1:0]   fb_meta,
  output logic               ready
);

  localparam int unsigned DEPTH = 1 << SCALE;

  typedef enum logic {INIT, RUN} state_t;

  state_t             r_state;
  logic [SCALE-1:0]   r_walk;
  logic [GHR_LEN-1:0] r_ghr;

  logic [1:0]         r_cnt [DEPTH];
  logic               r_val [DEPTH];
  logic [TAG_W-1:0]   r_tag [DEPTH];
  logic [XLEN-1:0]    r_tgt [DEPTH];

  logic [SCALE-1:0]   w_bidx;
  logic [SCALE-1:0]   w_cidx;
  logic [1:0]         w_cnt;
  logic               w_hit;
  logic               w_lookup;
  logic               w_fb;
  logic [SCALE-1:0]   w_fb_cidx;
  logic [1:0]         w_fb_cnt;
  logic [1:0]         w_fb_new;
  logic [SCALE-1:0]   w_fb_bidx;
  logic               w_unused;

  assign ready     = (r_state == RUN);
  assign w_lookup  = bp_oe && ready;
  assign w_fb      = fb_we && ready;

  // Reads see pre-edge table contents, so a same-edge update is not forwarded.
  assign w_bidx    = bp_pc[2 +: SCALE];
  assign w_cidx    = (MODE == 0) ? w_bidx : (w_bidx ^ SCALE'(r_ghr));
  assign w_cnt     = r_cnt[w_cidx];
  assign w_hit     = r_val[w_bidx] && (r_tag[w_bidx] == bp_pc[2+SCALE +: TAG_W]);

  assign w_fb_cidx = fb_meta[SCALE+1:2];
  assign w_fb_cnt  = fb_meta[1:0];
  assign w_fb_bidx = fb_pc[2 +: SCALE];
  assign w_unused  = ^{bp_pc, fb_pc, fb_target};

  always_comb begin
    w_fb_new = w_fb_cnt;
    if (fb_taken) begin
      if (w_fb_cnt != 2'b11) w_fb_new = w_fb_cnt + 2'd1;
    end else if (w_fb_cnt != 2'b00) begin
      w_fb_new = w_fb_cnt - 2'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= INIT;
      r_walk    <= '0;
      r_ghr     <= '0;
      bp_taken  <= 1'b0;
      bp_target <= '0;
      bp_meta   <= '0;
    end else begin
      case (r_state)
        INIT: begin
          r_walk <= r_walk + 1'b1;
          if (r_walk == '1) r_state <= RUN;
        end
        RUN: begin
          if (w_lookup) begin
            bp_taken  <= w_cnt[1] && w_hit;
            bp_target <= w_hit ? r_tgt[w_bidx] : '0;
            bp_meta   <= {w_cidx, w_cnt};
          end
          if (w_fb) r_ghr <= GHR_LEN'({r_ghr, fb_taken});
        end
        default: r_state <= INIT;
      endcase
    end
  end

  // Table storage carries no reset; the INIT walk initialises it.
  always_ff @(posedge clk) begin
    if (r_state == INIT) begin
      r_cnt[r_walk] <= 2'b01;
      r_val[r_walk] <= 1'b0;
    end else if (w_fb) begin
      r_cnt[w_fb_cidx] <= w_fb_new;
      if (fb_taken) begin
        r_val[w_fb_bidx] <= 1'b1;
        r_tag[w_fb_bidx] <= fb_pc[2+SCALE +: TAG_W];
        r_tgt[w_fb_bidx] <= {fb_target[XLEN-1:1], 1'b0};
      end
    end
  end

endmodule

// File: tb/tb_gshare_btb_predictor.sv
// Directed plus random check of gshare_btb_predictor (SCALE=4) in bimodal and gshare modes
// against an arithmetic reference model of the prediction tables.
module tb_gshare_btb_predictor;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        bp_oe = 1'b0;
  logic [31:0] bp_pc = '0;
  logic        fb_we = 1'b0;
  logic [31:0] fb_pc = '0;
  logic        fb_taken = 1'b0;
  logic [31:0] fb_target = '0;
  logic [5:0]  fb_meta = '0;

  logic        tk0, tk1, rdy0, rdy1;
  logic [31:0] tg0, tg1;
  logic [5:0]  mt0, mt1;

  int n_vec = 0;
  int n_err = 0;

  int unsigned m_cnt [16];
  bit          m_val [16];
  int unsigned m_tag [16];
  int unsigned m_tgt [16];
  int unsigned m_ghr;
  int unsigned m_walk;
  bit          m_ready;
  logic        e_taken [2];
  logic [31:0] e_tgt [2];
  logic [5:0]  e_meta [2];

  always #5 clk = ~clk;

  gshare_btb_predictor #(.XLEN(32), .SCALE(4), .TAG_W(8), .GHR_LEN(4), .MODE(0)) u_bim (
    .clk(clk), .rst(rst), .bp_oe(bp_oe), .bp_pc(bp_pc),
    .bp_taken(tk0), .bp_target(tg0), .bp_meta(mt0),
    .fb_we(fb_we), .fb_pc(fb_pc), .fb_taken(fb_taken), .fb_target(fb_target),
    .fb_meta(fb_meta), .ready(rdy0));

  gshare_btb_predictor #(.XLEN(32), .SCALE(4), .TAG_W(8), .GHR_LEN(4), .MODE(1)) u_gsh (
    .clk(clk), .rst(rst), .bp_oe(bp_oe), .bp_pc(bp_pc),
    .bp_taken(tk1), .bp_target(tg1), .bp_meta(mt1),
    .fb_we(fb_we), .fb_pc(fb_pc), .fb_taken(fb_taken), .fb_target(fb_target),
    .fb_meta(fb_meta), .ready(rdy1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_cnt[i] = 1; m_val[i] = 0; m_tag[i] = 0; m_tgt[i] = 0;
    end
    m_ghr = 0; m_walk = 0; m_ready = 0;
    for (int m = 0; m < 2; m++) begin
      e_taken[m] = 1'b0; e_tgt[m] = '0; e_meta[m] = '0;
    end
  endtask

  // Applies the rules for one rising edge using the inputs currently driven.
  task automatic model_edge();
    int unsigned bi, ci, c;
    bit hit;
    if (!m_ready) begin
      m_walk++;
      if (m_walk == 16) m_ready = 1;
      return;
    end
    if (bp_oe) begin
      bi  = (bp_pc >> 2) % 16;
      hit = m_val[bi] && (m_tag[bi] == ((bp_pc >> 6) % 256));
      for (int m = 0; m < 2; m++) begin
        ci = (m == 1) ? (bi ^ m_ghr) : bi;
        c  = m_cnt[ci];
        e_taken[m] = hit && (c >= 2);
        e_tgt[m]   = hit ? (m_tgt[bi] & 32'hFFFF_FFFE) : 32'h0;
        e_meta[m]  = 6'(ci * 4 + c);
      end
    end
    if (fb_we) begin
      ci = fb_meta / 4;
      c  = fb_meta % 4;
      m_cnt[ci] = fb_taken ? ((c == 3) ? 3 : c + 1) : ((c == 0) ? 0 : c - 1);
      if (fb_taken) begin
        bi = (fb_pc >> 2) % 16;
        m_val[bi] = 1;
        m_tag[bi] = (fb_pc >> 6) % 256;
        m_tgt[bi] = fb_target & 32'hFFFF_FFFE;
      end
      m_ghr = ((m_ghr * 2) + (fb_taken ? 1 : 0)) % 16;
    end
  endtask

  task automatic check_all();
    chk("bim_ready",  32'(rdy0), 32'(m_ready));
    chk("bim_taken",  32'(tk0),  32'(e_taken[0]));
    chk("bim_target", tg0,       e_tgt[0]);
    chk("bim_meta",   32'(mt0),  32'(e_meta[0]));
    chk("gsh_ready",  32'(rdy1), 32'(m_ready));
    chk("gsh_taken",  32'(tk1),  32'(e_taken[1]));
    chk("gsh_target", tg1,       e_tgt[1]);
    chk("gsh_meta",   32'(mt1),  32'(e_meta[1]));
  endtask

  // Starts and ends with clk low (just after a falling edge).
  task automatic step(input logic oe, input logic [31:0] pc, input logic we,
                      input logic [31:0] fpc, input logic ft, input logic [31:0] ftg,
                      input logic [5:0] fm);
    bp_oe = oe; bp_pc = pc; fb_we = we; fb_pc = fpc;
    fb_taken = ft; fb_target = ftg; fb_meta = fm;
    @(posedge clk);
    model_edge();
    #1 check_all();
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b0, '0, 1'b0, '0, 1'b0, '0, '0);
  endtask

  task automatic lookup(input logic [31:0] pc);
    step(1'b1, pc, 1'b0, '0, 1'b0, '0, '0);
  endtask

  task automatic feedback(input logic [31:0] fpc, input logic ft, input logic [31:0] ftg,
                          input logic [5:0] fm);
    step(1'b0, '0, 1'b1, fpc, ft, ftg, fm);
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    bp_oe = 1'b0; fb_we = 1'b0;
    #1 model_reset();
    check_all();
    repeat (cycles) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    model_reset();
    do_reset(3);

    for (int i = 0; i < 16; i++) begin
      idle();
      chk("walk_ready", 32'(rdy0), (i == 15) ? 32'd1 : 32'd0);
    end

    lookup(32'h40);
    chk("init_taken", 32'(tk0), 32'd0);
    chk("init_meta",  32'(mt1), 32'h01);

    feedback(32'h40, 1'b1, 32'h101, 6'h01);
    feedback(32'h40, 1'b1, 32'h101, 6'h02);
    lookup(32'h40);
    chk("hit_taken",  32'(tk0), 32'd1);
    chk("hit_target", tg0,      32'h100);
    chk("hit_meta",   32'(mt0), 32'h03);

    lookup(32'h440);
    chk("tagmiss_taken",  32'(tk0), 32'd0);
    chk("tagmiss_target", tg0,      32'h0);

    feedback(32'h40, 1'b1, 32'h101, 6'h03);
    lookup(32'h40);
    chk("sat_hi_meta", 32'(mt0), 32'h03);
    feedback(32'h40, 1'b0, 32'h0, 6'h00);
    lookup(32'h40);
    chk("sat_lo_meta",  32'(mt0), 32'h00);
    chk("sat_lo_taken", 32'(tk0), 32'd0);

    do_reset(2);
    repeat (16) idle();
    feedback(32'h80, 1'b1, 32'h300, 6'h15);
    feedback(32'h80, 1'b1, 32'h300, 6'h15);
    feedback(32'h80, 1'b0, 32'h300, 6'h15);
    feedback(32'h80, 1'b1, 32'h300, 6'h15);
    lookup(32'h40);
    chk("ghr_meta", 32'(mt1), 32'h35);
    step(1'b1, 32'h40, 1'b1, 32'h40, 1'b1, 32'h500, 6'h35);
    chk("same_edge_meta", 32'(mt1), 32'h35);
    lookup(32'h40);

    do_reset(2);
    repeat (7) idle();
    do_reset(1);
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 32'h40, 1'b1, 32'h40, 1'b1, 32'h200, 6'h02);
      chk("rewalk_ready", 32'(rdy1), (i == 15) ? 32'd1 : 32'd0);
    end
    lookup(32'h40);
    chk("init_fb_taken",  32'(tk1), 32'd0);
    chk("init_fb_target", tg1,      32'h0);
    chk("init_fb_meta",   32'(mt1), 32'h01);

    for (int i = 0; i < 400; i++) begin
      if (i == 200) do_reset(1);
      step(1'($urandom_range(0, 1)), $urandom & 32'h1FC,
           1'($urandom_range(0, 1)), $urandom & 32'h1FC,
           1'($urandom_range(0, 1)), $urandom, 6'($urandom_range(0, 63)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
